// File: rtl/midi_voice_pool_pkg.sv
// Shared definitions for the polyphonic MIDI voice pool.
// Provides the FSM state encoding, the velocity scaling shift and the
// note-to-phase-increment table generator (evaluated at elaboration only).
package midi_pkg;

  // Velocity is a 7-bit magnitude, so w * velocity >>> 7 keeps full scale.
  localparam int VEL_SHIFT = 7;
  localparam int NOTE_W    = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  // Phase increment for MIDI note n at 48 kHz: round(f(n) * 2^phase_w / 48000),
  // f(n) = 440 * 2^((n-69)/12). Only ever called with constant arguments to
  // build a ROM, never in datapath logic. The real->longint cast rounds.
  function automatic longint phase_incr(input int n, input int phase_w);
    real f;
    real r;
    f = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0));
    r = f * (2.0 ** real'(phase_w)) / 48000.0;
    return longint'(r);
  endfunction

endpackage

// File: rtl/midi_voice_pool_if.sv
// Note-event / sample-request bus for midi_voice_pool.
// master: note source and sample consumer; slave: the voice pool.
// Carries the note handshake, all_notes_off, wave select and the mixed sample.
interface midi_voice_pool_if #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 16
) ();

  logic                       note_valid;
  logic                       note_ready;
  logic [6:0]                 note_number;
  logic [6:0]                 note_velocity;
  logic                       all_notes_off;
  logic                       wave_sel;
  logic                       generate_next;
  logic signed [SAMPLE_W-1:0] sample_out;
  logic                       sample_out_ready;
  logic [NUM_VOICES-1:0]      voices_active;

  modport master (
    output note_valid, note_number, note_velocity, all_notes_off, wave_sel, generate_next,
    input  note_ready, sample_out, sample_out_ready, voices_active
  );

  modport slave (
    input  note_valid, note_number, note_velocity, all_notes_off, wave_sel, generate_next,
    output note_ready, sample_out, sample_out_ready, voices_active
  );

endinterface

// File: rtl/midi_voice_alloc.sv
// Voice allocator: finds the voice holding a note, the lowest free voice and the
// oldest voice, picks the note-on target and computes the post-allocation ages.
// Purely combinational; ports: per-voice active/note/age in, chosen index + ages out.
module midi_voice_alloc #(
  parameter int NUM_VOICES = 4,
  localparam int VIDX_W    = $clog2(NUM_VOICES)
) (
  input  logic [NUM_VOICES-1:0]             active,
  input  logic [NUM_VOICES-1:0][6:0]        note,
  input  logic [NUM_VOICES-1:0][VIDX_W-1:0] age,
  input  logic [6:0]                        ev_note,
  output logic                              hit,
  output logic [VIDX_W-1:0]                 hit_idx,
  output logic [VIDX_W-1:0]                 chosen_idx,
  output logic [NUM_VOICES-1:0][VIDX_W-1:0] age_next
);

  localparam logic [VIDX_W-1:0] AGE_MAX = VIDX_W'(NUM_VOICES - 1);

  logic              free_hit;
  logic [VIDX_W-1:0] free_idx;
  logic [VIDX_W-1:0] oldest_idx;
  logic [VIDX_W-1:0] oldest_age;

  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_hit   = 1'b0;
    free_idx   = '0;
    oldest_idx = '0;
    oldest_age = age[0];

    // Scanning downwards lets the lowest matching index win.
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (active[i] && note[i] == ev_note) begin
        hit     = 1'b1;
        hit_idx = VIDX_W'(i);
      end
      if (!active[i]) begin
        free_hit = 1'b1;
        free_idx = VIDX_W'(i);
      end
    end

    // Strict '>' keeps the lowest index on equal ages.
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age[i] > oldest_age) begin
        oldest_age = age[i];
        oldest_idx = VIDX_W'(i);
      end
    end

    chosen_idx = hit ? hit_idx : (free_hit ? free_idx : oldest_idx);

    for (int i = 0; i < NUM_VOICES; i++) begin
      if (VIDX_W'(i) == chosen_idx)
        age_next[i] = '0;
      else if (active[i] && age[i] != AGE_MAX)
        age_next[i] = age[i] + 1'b1;
      else
        age_next[i] = age[i];
    end
  end

endmodule

// File: rtl/midi_voice_pool.sv
// Polyphonic voice pool: allocates note events to NUM_VOICES oscillators and mixes
// them into one PCM sample per generate_next; latency NUM_VOICES+1 cycles.
// note_ready only in IDLE; generate_next outside IDLE is dropped, not queued.
// Ports: clk, reset_n (async active-low), bus (midi_voice_pool_if slave).
module midi_voice_pool
  import midi_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 16,
  parameter int PHASE_W    = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  midi_voice_pool_if.slave bus
);

  localparam int VIDX_W = $clog2(NUM_VOICES);
  localparam int ACC_W  = SAMPLE_W + VIDX_W + 1;
  localparam int PROD_W = SAMPLE_W + 8;

  localparam logic [SAMPLE_W-1:0]        SIGN_BIT = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic signed [SAMPLE_W-1:0] SQ_HI    = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] SQ_LO    = {1'b1, {(SAMPLE_W-2){1'b0}}, 1'b1};

  // Per-voice state
  logic [NUM_VOICES-1:0]              active;
  logic [NUM_VOICES-1:0][6:0]         note;
  logic [NUM_VOICES-1:0][6:0]         vel;
  logic [NUM_VOICES-1:0][PHASE_W-1:0] phase;
  logic [NUM_VOICES-1:0][VIDX_W-1:0]  age;

  // Sequencer / mixer state
  state_t                     state;
  logic [VIDX_W-1:0]          v;
  logic signed [ACC_W-1:0]    acc;
  logic                       wave_lat;
  logic                       note_ready_q;
  logic signed [SAMPLE_W-1:0] sample_q;
  logic                       sample_rdy_q;

  // Note-number -> phase increment ROM, fixed at elaboration.
  logic [PHASE_W-1:0] incr_rom [128];
  for (genvar g = 0; g < 128; g++) begin : g_incr
    localparam longint INC = phase_incr(g, PHASE_W);
    assign incr_rom[g] = INC[PHASE_W-1:0];
  end

  // Allocation
  logic                              hit;
  logic [VIDX_W-1:0]                 hit_idx;
  logic [VIDX_W-1:0]                 chosen_idx;
  logic [NUM_VOICES-1:0][VIDX_W-1:0] age_next;

  midi_voice_alloc #(.NUM_VOICES(NUM_VOICES)) u_alloc (
    .active     (active),
    .note       (note),
    .age        (age),
    .ev_note    (bus.note_number),
    .hit        (hit),
    .hit_idx    (hit_idx),
    .chosen_idx (chosen_idx),
    .age_next   (age_next)
  );

  // Mixer datapath for the voice selected by v. The waveform is taken from the
  // advanced phase, so the first sample after a note-on is one step in.
  logic [PHASE_W-1:0]         cur_phase_next;
  logic signed [SAMPLE_W-1:0] wave;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    contrib;
  logic signed [ACC_W-1:0]    acc_next;
  logic signed [SAMPLE_W-1:0] sample_next;

  always_comb begin
    cur_phase_next = phase[v] + incr_rom[note[v]];
    if (wave_lat)
      wave = cur_phase_next[PHASE_W-1] ? SQ_LO : SQ_HI;
    else
      wave = $signed(cur_phase_next[PHASE_W-1 -: SAMPLE_W] ^ SIGN_BIT);
    prod        = PROD_W'(wave) * PROD_W'($signed({1'b0, vel[v]}));
    contrib     = active[v] ? ACC_W'(prod >>> VEL_SHIFT) : '0;
    acc_next    = acc + contrib;
    // The accumulator carries headroom for NUM_VOICES full-scale voices, so
    // dividing by the voice count always fits SAMPLE_W.
    sample_next = SAMPLE_W'(acc_next >>> VIDX_W);
  end

  wire note_acc = bus.note_valid && note_ready_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active       <= '0;
      note         <= '0;
      vel          <= '0;
      phase        <= '0;
      age          <= '0;
      state        <= ST_IDLE;
      v            <= '0;
      acc          <= '0;
      wave_lat     <= 1'b0;
      note_ready_q <= 1'b0;
      sample_q     <= '0;
      sample_rdy_q <= 1'b0;
    end else begin
      // Note events only complete in IDLE (note_ready_q), so they never
      // collide with the ACCUM phase writes below.
      if (bus.all_notes_off) begin
        active <= '0;
      end else if (note_acc) begin
        if (bus.note_velocity != 7'd0) begin
          active[chosen_idx] <= 1'b1;
          note[chosen_idx]   <= bus.note_number;
          vel[chosen_idx]    <= bus.note_velocity;
          phase[chosen_idx]  <= '0;
          age                <= age_next;
        end else if (hit) begin
          active[hit_idx] <= 1'b0;
        end
      end

      case (state)
        ST_IDLE: begin
          if (bus.generate_next) begin
            acc          <= '0;
            wave_lat     <= bus.wave_sel;
            v            <= '0;
            state        <= ST_ACCUM;
            note_ready_q <= 1'b0;
          end else begin
            note_ready_q <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (active[v])
            phase[v] <= cur_phase_next;
          acc <= acc_next;
          v   <= v + 1'b1;
          if (v == VIDX_W'(NUM_VOICES - 1)) begin
            sample_q     <= sample_next;
            sample_rdy_q <= 1'b1;
            state        <= ST_OUT;
          end
        end
        ST_OUT: begin
          sample_rdy_q <= 1'b0;
          note_ready_q <= 1'b1;
          state        <= ST_IDLE;
        end
        default: begin
          sample_rdy_q <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.note_ready       = note_ready_q;
  assign bus.sample_out       = sample_q;
  assign bus.sample_out_ready = sample_rdy_q;
  assign bus.voices_active    = active;

endmodule

// File: tb/tb_midi_voice_pool.sv
// Bench for midi_voice_pool: directed scenarios plus randomized note traffic,
// compared against a behavioural voice/mixer model kept in plain arrays.
module tb_midi_voice_pool;

  localparam int NV = 4;
  localparam int SW = 16;
  localparam int PW = 24;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  midi_voice_pool_if #(.NUM_VOICES(NV), .SAMPLE_W(SW)) bus ();

  midi_voice_pool #(.NUM_VOICES(NV), .SAMPLE_W(SW), .PHASE_W(PW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit     m_active [NV];
  int     m_note   [NV];
  int     m_vel    [NV];
  int     m_age    [NV];
  longint m_phase  [NV];

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint m_incr(input int n);
    real f;
    f = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0));
    return longint'(f * (2.0 ** real'(PW)) / 48000.0);
  endfunction

  function automatic longint floor_div(input longint a, input longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic longint exp_active();
    longint r = 0;
    for (int i = 0; i < NV; i++) if (m_active[i]) r |= (longint'(1) << i);
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_active[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0; m_phase[i] = 0;
    end
  endfunction

  function automatic void model_note(input int n, input int vel);
    int ch = -1;
    if (vel == 0) begin
      for (int i = 0; i < NV; i++) if (m_active[i] && m_note[i] == n) m_active[i] = 0;
      return;
    end
    for (int i = 0; i < NV && ch < 0; i++) if (m_active[i] && m_note[i] == n) ch = i;
    for (int i = 0; i < NV && ch < 0; i++) if (!m_active[i]) ch = i;
    if (ch < 0) begin
      ch = 0;
      for (int i = 1; i < NV; i++) if (m_age[i] > m_age[ch]) ch = i;
    end
    for (int i = 0; i < NV; i++)
      if (i != ch && m_active[i] && m_age[i] < NV - 1) m_age[i]++;
    m_age[ch] = 0; m_active[ch] = 1; m_note[ch] = n; m_vel[ch] = vel; m_phase[ch] = 0;
  endfunction

  function automatic longint model_sample(input bit ws);
    longint sum = 0;
    longint w;
    longint full = longint'(1) << PW;
    for (int i = 0; i < NV; i++) begin
      if (m_active[i]) begin
        m_phase[i] = (m_phase[i] + m_incr(m_note[i])) % full;
        if (ws) w = (m_phase[i] >= full / 2) ? -32767 : 32767;
        else    w = (m_phase[i] >> (PW - SW)) - 32768;
        sum += floor_div(w * m_vel[i], 128);
      end
    end
    return floor_div(sum, NV);
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_note_ready();
    int n = 0;
    while (!bus.note_ready && n < 20) begin step(); n++; end
    check("note_ready_timeout", bus.note_ready, 1);
  endtask

  task automatic collect(input bit ws, output int s);
    longint exp;
    int lat = 1;
    exp = model_sample(ws);
    while (!bus.sample_out_ready && lat < 20) begin step(); lat++; end
    check("latency", lat, NV + 1);
    check("sample", bus.sample_out, exp);
    s = int'(bus.sample_out);
    step();  // leave OUT so the next request lands in IDLE
  endtask

  task automatic gen(input bit ws, output int s);
    bus.generate_next = 1; bus.wave_sel = ws;
    step();
    bus.generate_next = 0;
    collect(ws, s);
  endtask

  task automatic send_note(input int n, input int vel, input bit with_gen, input bit ws);
    int s;
    wait_note_ready();
    bus.note_valid = 1; bus.note_number = 7'(n); bus.note_velocity = 7'(vel);
    if (with_gen) begin bus.generate_next = 1; bus.wave_sel = ws; end
    step();
    bus.note_valid = 0; bus.generate_next = 0;
    model_note(n, vel);
    if (with_gen) collect(ws, s);
  endtask

  initial begin
    int s, prev, wraps, peak, strobes, first, smp;
    bus.note_valid = 0; bus.note_number = 0; bus.note_velocity = 0;
    bus.all_notes_off = 0; bus.wave_sel = 0; bus.generate_next = 0;
    reset_n = 0;
    model_reset();
    repeat (3) step();
    check("rst_sample_out", bus.sample_out, 0);
    check("rst_sample_rdy", bus.sample_out_ready, 0);
    check("rst_voices", bus.voices_active, 0);
    check("rst_note_ready", bus.note_ready, 0);
    reset_n = 1;
    step();
    check("note_ready_after_rst", bus.note_ready, 1);

    // 1: single A4 sawtooth, ~109 samples per period
    send_note(69, 127, 0, 0);
    check("a4_active", bus.voices_active, exp_active());
    wraps = 0; peak = -100000;
    gen(0, prev);
    for (int k = 1; k < 1100; k++) begin
      gen(0, s);
      if (s < prev) wraps++;
      if (s > peak) peak = s;
      prev = s;
    end
    check("a4_wraps", wraps, 10);
    check("a4_peak_near_fullscale", (peak > 7900 && peak <= 8127), 1);
    gen(1, s);
    check("a4_square_level", (s == 8127 || s == -8128), 1);

    // 2: fill the pool then steal the oldest (note 60 on voice 0)
    bus.all_notes_off = 1; step(); bus.all_notes_off = 0;
    model_reset_actives();
    check("anf_clear", bus.voices_active, 0);
    send_note(60, 100, 0, 0); send_note(64, 90, 0, 0);
    send_note(67, 80, 0, 0);  send_note(72, 70, 0, 0);
    check("pool_full", bus.voices_active, 4'b1111);
    send_note(76, 110, 0, 0);
    check("steal_active", bus.voices_active, 4'b1111);
    gen(bit'($urandom_range(0, 1)), s);
    send_note(60, 0, 0, 0);
    check("stolen_note_gone", bus.voices_active, 4'b1111);
    send_note(76, 0, 0, 0);
    check("steal_was_voice0", bus.voices_active, 4'b1110);

    // 3: note-off of an unheld note is accepted and ignored
    send_note(50, 0, 0, 0);
    check("noteoff_unheld", bus.voices_active, 4'b1110);
    send_note(64, 0, 0, 0);
    check("noteoff_64", bus.voices_active, 4'b1100);
    check("noteoff_model", bus.voices_active, exp_active());

    // 4: all_notes_off beats a simultaneous note-on
    wait_note_ready();
    bus.all_notes_off = 1; bus.note_valid = 1; bus.note_number = 62; bus.note_velocity = 100;
    step();
    bus.all_notes_off = 0; bus.note_valid = 0;
    model_reset_actives();
    check("anf_priority", bus.voices_active, 0);
    gen(0, s);
    check("silent_sample", s, 0);

    // 5: generate_next during ACCUM is ignored
    send_note(57, 127, 0, 0);
    send_note(61, 64, 0, 0);
    bus.generate_next = 1; bus.wave_sel = 0;
    step();
    bus.generate_next = 0;
    smp = int'(model_sample(0));
    strobes = 0; first = 0; s = 0;
    for (int c = 1; c <= 15; c++) begin
      if (bus.sample_out_ready) begin
        strobes++;
        if (first == 0) begin first = c; s = int'(bus.sample_out); end
      end
      bus.generate_next = (c == 2);
      step();
    end
    bus.generate_next = 0;
    check("one_strobe", strobes, 1);
    check("strobe_cycle", first, NV + 1);
    check("pulsed_sample", s, smp);

    // 6: reset in the middle of ACCUM
    bus.generate_next = 1;
    step();
    bus.generate_next = 0;
    step();
    reset_n = 0;
    #1;
    check("midrst_sample_out", bus.sample_out, 0);
    check("midrst_rdy", bus.sample_out_ready, 0);
    check("midrst_voices", bus.voices_active, 0);
    check("midrst_note_ready", bus.note_ready, 0);
    strobes = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (bus.sample_out_ready || bus.note_ready) strobes++;
    end
    check("midrst_quiet", strobes, 0);
    reset_n = 1;
    model_reset();
    check("rel_note_ready_low", bus.note_ready, 0);
    step();
    check("rel_note_ready_high", bus.note_ready, 1);
    send_note(69, 100, 0, 0);
    gen(0, s);  // confirms phases restarted from 0

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      int kind = int'($urandom_range(0, 3));
      int n    = int'($urandom_range(60, 67));
      int vel  = int'($urandom_range(1, 127));
      bit ws   = bit'($urandom_range(0, 1));
      case (kind)
        0:       send_note(n, 0, 0, 0);
        3:       send_note(n, vel, 1, ws);
        default: send_note(n, vel, 0, 0);
      endcase
      check("rand_active", bus.voices_active, exp_active());
      gen(ws, s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic void model_reset_actives();
    for (int i = 0; i < NV; i++) m_active[i] = 0;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
